ci_window_loader: RTL and testbench

CI_WINDOW_LOADER -- requirements
Module: ci_window_loader

---
 rtl/ci_pkg.sv | 12 +
 rtl/ci_window_loader.sv | 115 +++++++++++
 tb/tb_ci_window_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ci_pkg.sv
// Shared constants and FSM state type for the CI window loader.
package ci_pkg;

  localparam int CI_WIDTH = 8;
  localparam int CI_SIZE  = 25;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } ci_state_e;

endpackage

// File: rtl/ci_window_loader.sv
// Collects SIZE pixels into a window, presents it until the consumer takes it.
// Optional running window sum is enabled by defining CI_WIN_SUM_EN.
module ci_window_loader
  import ci_pkg::*;
#(
  parameter int  WIDTH = CI_WIDTH,
  parameter int  SIZE  = CI_SIZE,
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int SUM_W = WIDTH + IDX_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_din_valid,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_din_ready,
  output logic             o_win_valid,
  input  logic             i_win_ready,
  output logic [WIDTH-1:0] o_win [SIZE],
  output logic [IDX_W-1:0] o_index
`ifdef CI_WIN_SUM_EN
  ,
  output logic [SUM_W-1:0] o_win_sum
`endif
);

  ci_state_e        state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [WIDTH-1:0] win_q [SIZE];

  logic accept;
  logic last_elem;

  // Clear overrides any accept or handshake happening in the same cycle.
  assign accept    = i_din_valid && (state_q == FILL) && !i_clear;
  assign last_elem = (index_q == IDX_W'(SIZE - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (accept && last_elem) state_d = HOLD;
        HOLD:    if (i_win_ready)         state_d = FILL;
        default:                          state_d = FILL;
      endcase
    end
  end

  always_comb begin
    o_din_ready = 1'b0;
    o_win_valid = 1'b0;
    case (state_q)
      FILL:    o_din_ready = 1'b1;
      HOLD:    o_win_valid = 1'b1;
      default: o_din_ready = 1'b0;
    endcase
  end

  always_comb begin
    index_d = index_q;
    if (i_clear) begin
      index_d = '0;
    end else if (accept) begin
      index_d = last_elem ? '0 : index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  // Storage is never wiped by clear or by the handshake; new pixels overwrite it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SIZE; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      win_q[index_q] <= i_din;
    end
  end

  assign o_win   = win_q;
  assign o_index = index_q;

`ifdef CI_WIN_SUM_EN
  logic [SUM_W-1:0] sum_q;

  // The first pixel of a window restarts the sum, so a clear needs no extra handling.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= (index_q == '0) ? SUM_W'(i_din) : sum_q + SUM_W'(i_din);
    end
  end

  assign o_win_sum = sum_q;
`endif

endmodule

// File: tb/tb_ci_window_loader.sv
// Scoreboard bench for ci_window_loader: expected windows are queued as pixels
// are driven and compared when the DUT raises o_win_valid.
module tb_ci_window_loader;

  localparam int W  = 8;
  localparam int S  = 25;
  localparam int IW = 5;
  localparam int SW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          dv;
  logic          wr;
  logic [W-1:0]  din;
  logic          dr;
  logic          wv;
  logic [W-1:0]  win [S];
  logic [IW-1:0] idx;
`ifdef CI_WIN_SUM_EN
  logic [SW-1:0] wsum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [S-1:0][W-1:0] win;
    logic [SW-1:0]       sum;
  } exp_t;

  exp_t exp_q[$];

  logic                m_hold;
  int                  m_idx;
  logic [S-1:0][W-1:0] m_win;
  logic [SW-1:0]       m_sum;
  logic                prev_wv = 1'b0;

  always #5 clk = ~clk;

  ci_window_loader #(
    .WIDTH(W),
    .SIZE (S)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_clear    (clr),
    .i_din_valid(dv),
    .i_din      (din),
    .o_din_ready(dr),
    .o_win_valid(wv),
    .i_win_ready(wr),
    .o_win      (win),
    .o_index    (idx)
`ifdef CI_WIN_SUM_EN
    ,
    .o_win_sum  (wsum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_idx  = 0;
    m_win  = '0;
    m_sum  = '0;
  endtask

  // One clock of stimulus; the reference model advances after the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    exp_t e;
    dv  = v;
    din = d;
    wr  = r;
    clr = c;
    @(posedge clk);
    #1;
    if (c) begin
      m_hold = 1'b0;
      m_idx  = 0;
    end else if (!m_hold) begin
      if (v) begin
        m_win[m_idx] = d;
        m_sum = (m_idx == 0) ? SW'(d) : m_sum + SW'(d);
        if (m_idx == S - 1) begin
          m_idx  = 0;
          m_hold = 1'b1;
          e.win  = m_win;
          e.sum  = m_sum;
          exp_q.push_back(e);
        end else begin
          m_idx++;
        end
      end
    end else if (r) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic stream(input int n, input int first, input int inc);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, W'(first + k * inc), 1'b0, 1'b0);
    end
  endtask

  // Compare each presented window against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (wv === 1'b1 && prev_wv !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("win_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < S; i++) begin
          check($sformatf("win[%0d]", i), 32'(win[i]), 32'(e.win[i]));
        end
`ifdef CI_WIN_SUM_EN
        check("win_sum", 32'(wsum), 32'(e.sum));
`endif
      end
    end
    prev_wv = wv;
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    dv  = 1'b0;
    wr  = 1'b0;
    din = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_win_valid", 32'(wv), 32'd0);
    check("rst_din_ready", 32'(dr), 32'd1);
    check("rst_index", 32'(idx), 32'd0);
    check("rst_win0", 32'(win[0]), 32'd0);
    check("rst_win24", 32'(win[S-1]), 32'd0);
`ifdef CI_WIN_SUM_EN
    check("rst_sum", 32'(wsum), 32'd0);
`endif
    rst = 1'b0;

    // Pixels 1..25 back to back, consumer not ready.
    stream(S - 1, 1, 1);
    check("w1_valid_early", 32'(wv), 32'd0);
    check("w1_index_24", 32'(idx), 32'd24);
    stream(1, S, 1);
    check("w1_valid", 32'(wv), 32'd1);
    check("w1_din_ready", 32'(dr), 32'd0);
    check("w1_index_wrap", 32'(idx), 32'd0);
`ifdef CI_WIN_SUM_EN
    check("w1_sum_325", 32'(wsum), 32'd325);
`endif

    // Pixels offered while holding are ignored.
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'd99, 1'b0, 1'b0);
    check("hold_index", 32'(idx), 32'd0);
    check("hold_win0", 32'(win[0]), 32'd1);
    check("hold_valid", 32'(wv), 32'd1);

    // Handshake, then storage retained until overwritten.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("hs_valid_fall", 32'(wv), 32'd0);
    check("hs_din_ready", 32'(dr), 32'd1);
    check("hs_win5_kept", 32'(win[5]), 32'd6);
    stream(S, 26, 1);
    check("w2_valid", 32'(wv), 32'd1);
`ifdef CI_WIN_SUM_EN
    check("w2_sum_950", 32'(wsum), 32'd950);
`endif

    // Valid together with the handshake: no same-cycle accept.
    cycle(1'b1, 8'd77, 1'b1, 1'b0);
    check("nobypass_index", 32'(idx), 32'd0);
    check("nobypass_win0", 32'(win[0]), 32'd26);

    // Partial fill aborted by a clear with a concurrent pixel.
    stream(10, 8'hFF, 0);
    check("pre_clr_index", 32'(idx), 32'd10);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    check("clr_index", 32'(idx), 32'd0);
    check("clr_win0_kept", 32'(win[0]), 32'd255);
    check("clr_win10_nowrite", 32'(win[10]), 32'd36);
    stream(S - 1, 2, 0);
    check("clr_valid_early", 32'(wv), 32'd0);
    stream(1, 2, 0);
    check("clr_valid", 32'(wv), 32'd1);
`ifdef CI_WIN_SUM_EN
    check("clr_sum_50", 32'(wsum), 32'd50);
`endif

    // Clear while holding returns to filling.
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("clr_hold_valid", 32'(wv), 32'd0);
    check("clr_hold_ready", 32'(dr), 32'd1);

    // Full-scale window for the sum width.
    stream(S, 8'hFF, 0);
    check("max_valid", 32'(wv), 32'd1);
`ifdef CI_WIN_SUM_EN
    check("max_sum_6375", 32'(wsum), 32'd6375);
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a fill.
    stream(12, 100, 1);
    check("pre_rst_index", 32'(idx), 32'd12);
    dv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_index", 32'(idx), 32'd0);
    check("arst_win0", 32'(win[0]), 32'd0);
    check("arst_win11", 32'(win[11]), 32'd0);
    check("arst_win24", 32'(win[S-1]), 32'd0);
    check("arst_valid", 32'(wv), 32'd0);
`ifdef CI_WIN_SUM_EN
    check("arst_sum", 32'(wsum), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    stream(S - 1, 3, 2);
    check("post_rst_valid_early", 32'(wv), 32'd0);
    stream(1, 3 + (S - 1) * 2, 2);
    check("post_rst_valid", 32'(wv), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    check("windows_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
